x25519_byte_stream: RTL and testbench



---
 rtl/x25519_byte_stream.sv | 122 ++++++++++++
 tb/tb_x25519_byte_stream.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x25519_byte_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : x25519_byte_stream                                               |
// | Purpose : Byte-serial request/response wrapper around the curve25519 core. |
// |           Collects a 64-byte request, clamps the scalar, launches the core |
// |           and streams the 32-byte result back out.                        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module x25519_byte_stream (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic         out_last,
    output logic         core_start,
    output logic [254:0] core_scalar,
    output logic [254:0] core_point,
    input  logic         core_done,
    input  logic [254:0] core_out
);

    localparam logic [2:0] c_ST_LOAD      = 3'd0;
    localparam logic [2:0] c_ST_KICK      = 3'd1;
    localparam logic [2:0] c_ST_WAIT_LOW  = 3'd2;
    localparam logic [2:0] c_ST_WAIT_HIGH = 3'd3;
    localparam logic [2:0] c_ST_SEND      = 3'd4;

    logic [2:0]   r_state;
    logic [2:0]   w_next_state;
    logic [5:0]   r_cnt;
    logic [511:0] r_req;
    logic         r_loaded;
    logic [254:0] r_result;
    logic [255:0] w_result_ext;
    logic         w_in_fire;
    logic         w_out_fire;
    logic         w_unused_bits;

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        core_start   = 1'b0;
        case (r_state)
            c_ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (r_cnt == 6'd63)) begin
                    w_next_state = c_ST_KICK;
                end
            end
            c_ST_KICK: begin
                core_start   = 1'b1;
                w_next_state = c_ST_WAIT_LOW;
            end
            c_ST_WAIT_LOW: begin
                // A done level still high from an earlier run must be seen low first.
                if (!core_done) begin
                    w_next_state = c_ST_WAIT_HIGH;
                end
            end
            c_ST_WAIT_HIGH: begin
                if (core_done) begin
                    w_next_state = c_ST_SEND;
                end
            end
            c_ST_SEND: begin
                out_valid = 1'b1;
                if (out_ready && (r_cnt == 6'd31)) begin
                    w_next_state = c_ST_LOAD;
                end
            end
            default: begin
                w_next_state = c_ST_LOAD;
            end
        endcase
    end

    assign w_in_fire  = in_valid && (r_state == c_ST_LOAD);
    assign w_out_fire = out_ready && (r_state == c_ST_SEND);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_ST_LOAD;
            r_cnt    <= 6'd0;
            r_loaded <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_in_fire) begin
                r_cnt    <= r_cnt + 6'd1;
                r_loaded <= (r_cnt == 6'd63);
            end else if (w_out_fire) begin
                r_cnt <= (r_cnt == 6'd31) ? 6'd0 : (r_cnt + 6'd1);
            end
            if ((r_state == c_ST_WAIT_HIGH) && core_done) begin
                r_result <= core_out;
            end
        end
    end

    // Request bytes need no reset: the operands are masked until a full request lands.
    always_ff @(posedge clock) begin
        if (w_in_fire) begin
            r_req[{r_cnt, 3'b000} +: 8] <= in_data;
        end
    end

    assign core_scalar = r_loaded ? {1'b1, r_req[253:3], 3'b000} : '0;
    assign core_point  = r_loaded ? r_req[510:256] : '0;

    assign w_result_ext = {1'b0, r_result};
    assign out_data     = w_result_ext[{r_cnt[4:0], 3'b000} +: 8];
    assign out_last     = (r_state == c_ST_SEND) && (r_cnt == 6'd31);

    assign w_unused_bits = ^{r_req[511], r_req[255:254], r_req[2:0]};

endmodule
`default_nettype wire

// File: tb/tb_x25519_byte_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_x25519_byte_stream                                            |
// | Purpose : Scoreboard bench for x25519_byte_stream with a stub ladder core. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_x25519_byte_stream;

    typedef logic [7:0] req_t [64];

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = 8'h00;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [7:0]   out_data;
    logic         out_last;
    logic         core_start;
    logic [254:0] core_scalar;
    logic [254:0] core_point;
    logic         core_done = 1'b1;
    logic [254:0] core_out = 255'h5a5a_dead_beef_0bad_cafe;

    x25519_byte_stream dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .core_start  (core_start),
        .core_scalar (core_scalar),
        .core_point  (core_point),
        .core_done   (core_done),
        .core_out    (core_out)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int checks = 0;
    int errors = 0;

    logic [8:0]   exp_bytes[$];
    logic [254:0] exp_s[$];
    logic [254:0] exp_p[$];
    bit           busy = 1'b0;
    int           rdy_mode = 0;
    int           out_idx = 0;
    bit           dir_next = 1'b0;
    bit           dir_run = 1'b0;
    int           kick_cyc = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic abort_timeout(input string name, input int waited);
        errors++;
        $display("FAIL timeout %s: waited %0d cycles, required completion", name, waited);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    function automatic logic [255:0] le_value(input req_t b, input int base);
        logic [255:0] v;
        v = '0;
        for (int i = 31; i >= 0; i--) v = (v << 8) + 256'(b[base + i]);
        return v;
    endfunction

    // Stub core transfer function: anything that mixes both operands will do.
    function automatic logic [254:0] stub_f(input logic [254:0] s, input logic [254:0] p);
        logic [255:0] t;
        t = {1'b0, s} + 256'd3 * {1'b0, p} + 256'd1;
        return t[254:0];
    endfunction

    task automatic push_request(input req_t b, input bit forced, input logic [254:0] forced_val);
        logic [255:0] s;
        logic [255:0] p;
        logic [255:0] r;
        s = le_value(b, 0) % (256'd1 << 255);
        s = s - (s % 256'd8);
        s = s | (256'd1 << 254);
        p = le_value(b, 32) % (256'd1 << 255);
        exp_s.push_back(s[254:0]);
        exp_p.push_back(p[254:0]);
        r = forced ? {1'b0, forced_val} : {1'b0, stub_f(s[254:0], p[254:0])};
        for (int i = 0; i < 32; i++) begin
            exp_bytes.push_back({(i == 31), r[8*i +: 8]});
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        do begin
            acc = in_ready;
            @(posedge clock);
            #1;
            t++;
            if (t > 5000) abort_timeout("in_ready", t);
        end while (!acc);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_request(input req_t b, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            if (i == 63) begin
                in_valid = 1'b1;
                in_data  = b[i];
                while (!in_ready) begin
                    @(posedge clock);
                    #1;
                end
                @(posedge clock);
                #1;
                in_valid = 1'b0;
                busy = 1'b1;
                check("launch_start", 256'(core_start), 256'd1);
                check("launch_in_ready", 256'(in_ready), 256'd0);
                @(posedge clock);
                #1;
                check("start_width", 256'(core_start), 256'd0);
            end else begin
                send_byte(b[i]);
            end
        end
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        #1;
        check("rst_out_valid", 256'(out_valid), 256'd0);
        check("rst_in_ready", 256'(in_ready), 256'd1);
        check("rst_core_start", 256'(core_start), 256'd0);
        check("rst_out_last", 256'(out_last), 256'd0);
        exp_bytes.delete();
        exp_s.delete();
        exp_p.delete();
        busy    = 1'b0;
        out_idx = 0;
        dir_run = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_bytes.size() != 0 || busy) begin
            @(posedge clock);
            #1;
            t++;
            if (t > 3000) abort_timeout("drain", t);
        end
    endtask

    task automatic rand_req(output req_t b);
        for (int i = 0; i < 64; i++) b[i] = 8'($urandom);
    endtask

    // Stub ladder core: stale done stays high until a random drop, then rises with a result.
    initial begin
        int drop;
        int busy_c;
        logic [254:0] pend;
        drop = -1;
        busy_c = -1;
        pend = '0;
        forever begin
            @(posedge clock);
            #1;
            if (core_start) begin
                if (exp_s.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_start: got core_start=1 required no launch");
                end else begin
                    check("core_scalar", {1'b0, core_scalar}, {1'b0, exp_s.pop_front()});
                    check("core_point", {1'b0, core_point}, {1'b0, exp_p.pop_front()});
                end
                kick_cyc = cyc;
                if (dir_next) begin
                    drop = 3;
                    busy_c = 20;
                    pend = 255'h1234;
                    dir_run = 1'b1;
                    dir_next = 1'b0;
                end else begin
                    drop = int'($urandom_range(0, 4));
                    busy_c = drop + int'($urandom_range(2, 16));
                    pend = stub_f(core_scalar, core_point);
                    dir_run = 1'b0;
                end
            end else begin
                if (drop > 0) drop--;
                if (drop == 0) begin
                    core_done = 1'b0;
                    core_out = 255'($urandom);
                    drop = -1;
                end
                if (busy_c > 0) busy_c--;
                if (busy_c == 0 && drop < 0) begin
                    core_done = 1'b1;
                    core_out = pend;
                    busy_c = -1;
                end
            end
        end
    end

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (ph % 4 == 0) || (ph % 4 == 3);
                    ph++;
                end
                default: out_ready = 1'($urandom);
            endcase
        end
    end

    // Monitor: in_ready/busy agreement, output hold while stalled, scoreboard pops.
    initial begin
        bit prev_stall;
        bit prev_valid;
        logic [7:0] prev_data;
        bit prev_last;
        logic [8:0] e;
        prev_stall = 1'b0;
        prev_valid = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_stall = 1'b0;
                prev_valid = 1'b0;
            end else begin
                check("in_ready_busy", 256'(in_ready), 256'(!busy));
                if (prev_stall) begin
                    check("hold_data", 256'(out_data), 256'(prev_data));
                    check("hold_last", 256'(out_last), 256'(prev_last));
                end
                if (out_valid && !prev_valid && dir_run) begin
                    check("stale_latency", 256'(cyc - kick_cyc), 256'd21);
                    dir_run = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (exp_bytes.size() == 0) begin
                        errors++;
                        $display("FAIL extra_byte: got %h required no output", out_data);
                    end else begin
                        e = exp_bytes.pop_front();
                        check("out_data", 256'(out_data), 256'(e[7:0]));
                        check("out_last", 256'(out_last), 256'(e[8]));
                        if (e[8]) begin
                            check("top_bit", 256'(out_data[7]), 256'd0);
                            busy = 1'b0;
                            out_idx = 0;
                        end else begin
                            out_idx++;
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_valid = out_valid;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    initial begin
        req_t b;
        int t;
        #1;
        check("rst_in_ready", 256'(in_ready), 256'd1);
        check("rst_out_valid", 256'(out_valid), 256'd0);
        check("rst_out_last", 256'(out_last), 256'd0);
        check("rst_out_data", 256'(out_data), 256'd0);
        check("rst_core_start", 256'(core_start), 256'd0);
        check("rst_core_scalar", {1'b0, core_scalar}, 256'd0);
        check("rst_core_point", {1'b0, core_point}, 256'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 64; i++) b[i] = 8'hFF;
        push_request(b, 1'b0, '0);
        send_request(b, 64);
        check("clamp_ff_scalar", {1'b0, core_scalar}, {1'b0, {252{1'b1}}, 3'b000});
        check("clamp_ff_point", {1'b0, core_point}, {1'b0, {255{1'b1}}});
        drain();

        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        push_request(b, 1'b0, '0);
        send_request(b, 64);
        check("clamp_00_scalar", {1'b0, core_scalar}, {2'b01, 254'd0});
        drain();

        dir_next = 1'b1;
        rand_req(b);
        push_request(b, 1'b1, 255'h1234);
        send_request(b, 64);
        drain();

        rdy_mode = 1;
        for (int n = 0; n < 5; n++) begin
            rand_req(b);
            push_request(b, 1'b0, '0);
            send_request(b, 64);
        end
        drain();

        rdy_mode = 2;
        for (int n = 0; n < 3; n++) begin
            rand_req(b);
            push_request(b, 1'b0, '0);
            send_request(b, 64);
        end
        drain();

        rdy_mode = 0;
        rand_req(b);
        push_request(b, 1'b0, '0);
        send_request(b, 64);
        t = 0;
        while (out_idx < 11) begin
            @(posedge clock);
            #2;
            t++;
            if (t > 3000) abort_timeout("send_progress", t);
        end
        reset_dut();

        rand_req(b);
        push_request(b, 1'b0, '0);
        send_request(b, 41);
        @(posedge clock);
        #1;
        reset_dut();

        rand_req(b);
        push_request(b, 1'b0, '0);
        send_request(b, 64);
        drain();

        check("leftover", 256'(exp_bytes.size()), 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
